dat_mem_ctl: RTL and testbench
==============================

Name: dat_mem_ctl

Overview:
Parametrised data memory with a request/response handshake, registered (1-cycle) reads and a built-in hardware stack (push/pop) sharing the same storage. It sits between the core's load/store unit and storage, and replaces the fixed 8x256 combinational-read memory. Overflow and underflow are detected and flagged rather than silently corrupting memory.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 256, number of words (any value >= 2; not required to be a power of 2)
ADDR_W, $clog2(DEPTH), address width (derived; not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_op  in  2  operation: LOAD=0, STORE=1, PUSH=2, POP=3
req_addr  in  ADDR_W  word address (LOAD/STORE only; ignored for PUSH/POP)
req_wdata  in  WIDTH  write data (STORE/PUSH)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  WIDTH  read data (LOAD/POP); 0 for STORE/PUSH and for errors
rsp_err  out  1  request failed (address >= DEPTH, push on full, pop on empty)
sp  out  ADDR_W+1  current stack pointer
stk_empty  out  1  sp == DEPTH
stk_full  out  1  sp == 0

Behaviour:
- Reset (rst_n=0 at clk edge): rsp_valid=0, rsp_data=0, rsp_err=0, sp=DEPTH, stk_empty=1, stk_full=0. Memory contents are not reset. Reset overrides any in-flight request or pending response, which is discarded.
- req_ready = !rsp_valid || rsp_ready. This is combinational, with no dependency on req_valid.
- Accept occurs when req_valid && req_ready at a clock edge. Exactly one response per accepted request. rsp_valid rises the cycle after acceptance (latency 1).
- Response registers hold stable while rsp_valid && !rsp_ready. rsp_valid clears on rsp_ready unless a new request is accepted the same cycle. Back-to-back throughput is 1 request/cycle when rsp_ready=1.
- LOAD: rsp_data = mem[req_addr]. If req_addr >= DEPTH: rsp_err=1, rsp_data=0.
- STORE: writes mem[req_addr] = req_wdata at the accept edge. If req_addr >= DEPTH: no write, rsp_err=1.
- PUSH: stack grows downward. If sp==0: no write, sp unchanged, rsp_err=1. Else write mem[sp-1] = req_wdata and sp <= sp-1.
- POP: if sp==DEPTH: sp unchanged, rsp_err=1, rsp_data=0. Else rsp_data = mem[sp] and sp <= sp+1.
- Read-after-write: a LOAD or POP accepted the cycle after a STORE or PUSH to the same word returns the new data. Write occurs at the earlier edge, so no bypass is needed.
- The stack region overlaps the normal address space. A STORE into stack words is legal and not checked.
- sp, stk_empty and stk_full are registered and update at the accept edge.
- Arithmetic: sp is ADDR_W+1 bits so that DEPTH is representable. No wrap-around is ever performed; the boundaries are trapped as errors.

Optional Feature:
DAT_MEM_TRACE_EN: when defined, each accepted request prints $display("[%0t] <OP>: addr=0x%0h data=0x%0h sp=%0d err=%0b"). Reads report the response data and writes report the write data. When undefined, no display statements are compiled and the RTL is fully synthesizable with no simulation-only code.

Decomposition:
- Package dat_mem_pkg: typedef enum logic[1:0] mem_op_e {OP_LOAD, OP_STORE, OP_PUSH, OP_POP}; also a response struct {data, err} parametrised by WIDTH via a localparam default of 8.
- Sub-module dat_mem_array: WIDTH x DEPTH storage, one synchronous write port and one registered read port.
- Top level: handshake, sp counter, bounds checks, response register.

Test Plan:
- Reset then idle: sp=256, stk_empty=1, rsp_valid=0, req_ready=1.
- STORE addr=0x10 data=0xA5, then LOAD addr=0x10: second response rsp_data=0xA5, rsp_err=0, one cycle after accept; back-to-back with no bubble.
- PUSH 0x11, 0x22, 0x33, then POP x3: sp goes 255, 254, 253 then back to 256. Pops return 0x33, 0x22, 0x11. stk_empty=1 at end.
- POP on empty: rsp_err=1, rsp_data=0, sp stays 256. With DEPTH=4, 5 PUSHes: the fifth gives rsp_err=1, sp stays 0, stk_full=1, and mem[0..3] is unchanged.
- Backpressure: hold rsp_ready=0 for 3 cycles after a LOAD. Required: rsp_data stable, req_ready=0, and no second request accepted until rsp_ready=1.
- DEPTH=200: LOAD addr=0xC8 returns rsp_err=1. Reset asserted mid-stream with rsp_valid=1 leaves rsp_valid=0 and sp=200 on the next cycle.

Source files
------------

// File: rtl/dat_mem_pkg.sv
// Shared types and helpers for the data memory controller with its built-in hardware stack.
package dat_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } mem_op_e;

  localparam int RSP_WIDTH = 8;

  typedef struct packed {
    logic [RSP_WIDTH-1:0] data;
    logic                 err;
  } mem_rsp_t;

  // DEPTH need not be a power of two, so the address range is checked explicitly.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/dat_mem_array.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered read port.
module dat_mem_array
  import dat_mem_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register: loads zero instead of memory for non-read or failed responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dat_mem_ctl.sv
// Data memory controller: req/rsp handshake, 1-cycle reads, downward stack sharing storage.
// Optional DAT_MEM_TRACE_EN compiles a per-request $display trace (simulation only).
module dat_mem_ctl
  import dat_mem_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W:0]   sp,
  output logic              stk_empty,
  output logic              stk_full
);

  localparam logic [ADDR_W:0] SP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] SP_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] SP_ZERO  = (ADDR_W+1)'(0);

  logic [ADDR_W:0]   sp_q, sp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;

  logic              accept_s;
  logic              addr_ok_s;
  mem_op_e           op_s;
  logic              we_s, re_s, rclr_s;
  logic [ADDR_W-1:0] waddr_s, raddr_s;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept_s  = req_valid && req_ready;
  assign op_s      = mem_op_e'(req_op);
  assign addr_ok_s = addr_in_range(32'(req_addr), DEPTH);

  // Decode the accepted request into memory strobes, stack pointer and response state.
  always_comb begin
    we_s        = 1'b0;
    re_s        = 1'b0;
    rclr_s      = 1'b0;
    waddr_s     = req_addr;
    raddr_s     = req_addr;
    sp_d        = sp_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    if (accept_s) begin
      rsp_valid_d = 1'b1;
      re_s        = 1'b1;
      rsp_err_d   = 1'b0;
      case (op_s)
        OP_LOAD: begin
          if (addr_ok_s) begin
            rclr_s = 1'b0;
          end else begin
            rclr_s    = 1'b1;
            rsp_err_d = 1'b1;
          end
        end
        OP_STORE: begin
          rclr_s = 1'b1;
          if (addr_ok_s) begin
            we_s = 1'b1;
          end else begin
            rsp_err_d = 1'b1;
          end
        end
        OP_PUSH: begin
          rclr_s = 1'b1;
          if (sp_q == SP_ZERO) begin
            rsp_err_d = 1'b1;
          end else begin
            we_s    = 1'b1;
            waddr_s = ADDR_W'(sp_q - SP_ONE);
            sp_d    = sp_q - SP_ONE;
          end
        end
        OP_POP: begin
          if (sp_q == SP_DEPTH) begin
            rclr_s    = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            raddr_s = sp_q[ADDR_W-1:0];
            sp_d    = sp_q + SP_ONE;
          end
        end
        default: begin
          rclr_s    = 1'b1;
          rsp_err_d = 1'b1;
        end
      endcase
    end else begin
      rsp_valid_d = rsp_valid_q && !rsp_ready;
    end
    empty_d = (sp_d == SP_DEPTH);
    full_d  = (sp_d == SP_ZERO);
  end

  // Response, stack pointer and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      sp_q        <= SP_DEPTH;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      sp_q        <= sp_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
    end
  end

  dat_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we_s),
    .waddr_i(waddr_s),
    .wdata_i(req_wdata),
    .re_i   (re_s),
    .rclr_i (rclr_s),
    .raddr_i(raddr_s),
    .rdata_o(rsp_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign sp        = sp_q;
  assign stk_empty = empty_q;
  assign stk_full  = full_q;

`ifdef DAT_MEM_TRACE_EN
  logic              trace_q;
  mem_op_e           trace_op_q;
  logic [ADDR_W-1:0] trace_addr_q;
  logic [WIDTH-1:0]  trace_wdata_q;

  // Trace prints one cycle after accept so read data is already in the response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trace_q <= 1'b0;
    end else begin
      trace_q <= accept_s;
      if (accept_s) begin
        trace_op_q    <= op_s;
        trace_addr_q  <= (op_s == OP_PUSH) ? waddr_s : ((op_s == OP_POP) ? raddr_s : req_addr);
        trace_wdata_q <= req_wdata;
      end
      if (trace_q) begin
        $display("[%0t] %s: addr=0x%0h data=0x%0h sp=%0d err=%0b", $time, trace_op_q.name(),
                 trace_addr_q,
                 ((trace_op_q == OP_LOAD) || (trace_op_q == OP_POP)) ? rsp_data : trace_wdata_q,
                 sp_q, rsp_err_q);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_dat_mem_ctl.sv
// Scoreboard bench for dat_mem_ctl: three instances (DEPTH 256, 4, 200) against a behavioural model.
module tb_dat_mem_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid [3];
  logic [1:0] req_op    [3];
  logic [7:0] req_addr  [3];
  logic [7:0] req_wdata [3];
  logic       rsp_ready [3];
  logic       req_ready [3];
  logic       rsp_valid [3];
  logic       rsp_err   [3];
  logic       stk_empty [3];
  logic       stk_full  [3];
  logic [7:0] rsp_data  [3];
  logic [8:0] sp0, sp2;
  logic [2:0] sp1;

  dat_mem_ctl #(.WIDTH(8), .DEPTH(256)) u_d256 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .sp(sp0), .stk_empty(stk_empty[0]), .stk_full(stk_full[0]));

  dat_mem_ctl #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1][1:0]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .sp(sp1), .stk_empty(stk_empty[1]), .stk_full(stk_full[1]));

  dat_mem_ctl #(.WIDTH(8), .DEPTH(200)) u_d200 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_op(req_op[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]),
    .rsp_err(rsp_err[2]), .sp(sp2), .stk_empty(stk_empty[2]), .stk_full(stk_full[2]));

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         s;
  } exp_t;

  exp_t sbq [3][$];
  int   mmem [3][256];
  int   msp  [3];
  int   mdep [3] = '{256, 4, 200};
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] get_sp(input int k);
    case (k)
      0:       return 32'(sp0);
      1:       return 32'(sp1);
      default: return 32'(sp2);
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: computes the expected response and queues it.
  task automatic model_op(input int k, input logic [1:0] op, input logic [7:0] addr,
                          input logic [7:0] wd);
    exp_t e;
    int   a;
    a   = (k == 1) ? int'(addr[1:0]) : int'(addr);
    e.d = 8'h00;
    e.e = 1'b0;
    case (op)
      2'd0: if (a >= mdep[k]) e.e = 1'b1; else e.d = 8'(mmem[k][a]);
      2'd1: if (a >= mdep[k]) e.e = 1'b1; else mmem[k][a] = int'(wd);
      2'd2: if (msp[k] == 0) e.e = 1'b1;
            else begin msp[k] = msp[k] - 1; mmem[k][msp[k]] = int'(wd); end
      default: if (msp[k] == mdep[k]) e.e = 1'b1;
               else begin e.d = 8'(mmem[k][msp[k]]); msp[k] = msp[k] + 1; end
    endcase
    e.s = msp[k];
    sbq[k].push_back(e);
  endtask

  task automatic do_req(input int k, input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_op[k]    = op;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      req_valid[k] = 1'b0;
    end else begin
      model_op(k, op, addr, wd);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      check_val("latency", 32'(rsp_valid[k]), 32'd1);
    end
  endtask

  // Response monitor: compares each consumed response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst_n && rsp_valid[k] && rsp_ready[k]) begin
        if (sbq[k].size() == 0) begin
          check_val("spurious_rsp", 32'd1, 32'd0);
        end else begin
          e = sbq[k].pop_front();
          check_val("rsp_data", 32'(rsp_data[k]), 32'(e.d));
          check_val("rsp_err", 32'(rsp_err[k]), 32'(e.e));
          check_val("sp", get_sp(k), 32'(e.s));
          check_val("stk_empty", 32'(stk_empty[k]), 32'(e.s == mdep[k]));
          check_val("stk_full", 32'(stk_full[k]), 32'(e.s == 0));
        end
      end
    end
  end

  initial begin
    int pending;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_op[k]    = 2'd0;
      req_addr[k]  = 8'h00;
      req_wdata[k] = 8'h00;
      rsp_ready[k] = 1'b1;
      msp[k]       = mdep[k];
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_sp256", get_sp(0), 32'd256);
    check_val("rst_sp4", get_sp(1), 32'd4);
    check_val("rst_sp200", get_sp(2), 32'd200);
    check_val("rst_empty", 32'(stk_empty[0]), 32'd1);
    check_val("rst_full", 32'(stk_full[0]), 32'd0);
    check_val("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check_val("rst_ready", 32'(req_ready[0]), 32'd1);
    check_val("rst_err", 32'(rsp_err[0]), 32'd0);
    check_val("rst_data", 32'(rsp_data[0]), 32'd0);

    // Store then load back-to-back, stack push/pop, pop on empty.
    do_req(0, 2'd1, 8'h10, 8'hA5);
    do_req(0, 2'd0, 8'h10, 8'h00);
    do_req(0, 2'd2, 8'h00, 8'h11);
    do_req(0, 2'd2, 8'h00, 8'h22);
    do_req(0, 2'd2, 8'h00, 8'h33);
    for (int i = 0; i < 3; i++) do_req(0, 2'd3, 8'h00, 8'h00);
    do_req(0, 2'd3, 8'h00, 8'h00);

    for (int i = 0; i < 4; i++) do_req(0, 2'd1, 8'h20 + 8'(i), 8'($urandom));
    for (int i = 0; i < 12; i++)
      do_req(0, 2'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 3)), 8'($urandom));

    // Backpressure: stalled LOAD response, competing STORE must not be accepted.
    repeat (2) @(negedge clk);
    rsp_ready[0] = 1'b0;
    do_req(0, 2'd0, 8'h10, 8'h00);
    req_valid[0] = 1'b1;
    req_op[0]    = 2'd1;
    req_addr[0]  = 8'h10;
    req_wdata[0] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_ready", 32'(req_ready[0]), 32'd0);
      check_val("stall_data", 32'(rsp_data[0]), 32'hA5);
      check_val("stall_valid", 32'(rsp_valid[0]), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    do_req(0, 2'd0, 8'h10, 8'h00);

    // DEPTH=4: overflow on fifth push, then drain and underflow.
    for (int i = 1; i <= 5; i++) do_req(1, 2'd2, 8'h00, 8'(i));
    for (int i = 0; i < 5; i++) do_req(1, 2'd3, 8'h00, 8'h00);

    // DEPTH=200: boundary addresses.
    do_req(2, 2'd1, 8'hC7, 8'h3C);
    do_req(2, 2'd0, 8'hC7, 8'h00);
    do_req(2, 2'd0, 8'hC8, 8'h00);
    do_req(2, 2'd1, 8'hC8, 8'h99);
    do_req(2, 2'd0, 8'hC7, 8'h00);

    // Reset with a stalled response pending discards it.
    repeat (2) @(negedge clk);
    rsp_ready[2] = 1'b0;
    do_req(2, 2'd2, 8'h00, 8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      msp[k] = mdep[k];
    end
    @(negedge clk);
    check_val("midrst_valid", 32'(rsp_valid[2]), 32'd0);
    check_val("midrst_sp", get_sp(2), 32'd200);
    check_val("midrst_empty", 32'(stk_empty[2]), 32'd1);
    rsp_ready[2] = 1'b1;
    do_req(2, 2'd3, 8'h00, 8'h00);

    pending = 0;
    for (int n = 0; n < 50; n++) begin
      pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
      if (pending != 0) @(negedge clk);
    end
    pending = sbq[0].size() + sbq[1].size() + sbq[2].size();
    check_val("drain", 32'(pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
